// File: rtl/conv1_pkg.sv
// conv1_pkg: frame geometry and sequencer state encoding shared by the conv1 frame control logic
package conv1_pkg;
  localparam int WIDTH = 28;
  localparam int HEIGHT = 28;
  localparam int FILTER_SIZE = 5;
  localparam int NUM_PIX = WIDTH * HEIGHT;
  localparam int OUT_W = WIDTH - FILTER_SIZE + 1;
  localparam int OUT_H = HEIGHT - FILTER_SIZE + 1;
  localparam int NUM_WIN = OUT_W * OUT_H;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_e;
endpackage

// File: rtl/conv1_raster_cnt.sv
// conv1_raster_cnt: enable-driven column/row raster counter with wrap and end-of-frame flag
module conv1_raster_cnt
  import conv1_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int H = HEIGHT,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);
  logic [CW-1:0] col_q, row_q;
  logic col_end;
  assign col_end = col_q == CW'(W - 1);
  assign last = col_end && row_q == CW'(H - 1);
  assign col = col_q;
  assign row = row_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      col_q <= col_end ? '0 : col_q + CW'(1);
      row_q <= col_end ? (last ? '0 : row_q + CW'(1)) : row_q;
    end
endmodule

// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl: reads one frame from a 1-cycle-latency pixel memory in raster order,
// streams it to the window buffer and tags pixels that complete a filter window
module conv1_frame_ctrl
  import conv1_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic [DATA_BITS-1:0] pix_out,
  output logic                 pix_valid,
  output logic                 win_valid,
  output logic [4:0]           win_row,
  output logic [4:0]           win_col,
  output logic                 busy,
  output logic                 frame_done
);
  state_e state_q, state_d;
  logic [ADDR_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic pix_valid_q, rd_last, d_last;
  logic [4:0] d_row, d_col, win_row_q, win_col_q;
  conv1_raster_cnt #(.W(WIDTH), .H(HEIGHT), .CW(5)) u_deliv (
    .clk (clk),
    .rst (rst),
    .en  (pix_valid_q),
    .col (d_col),
    .row (d_row),
    .last(d_last)
  );
  assign rd_last = rd_cnt_q == ADDR_BITS'(NUM_PIX - 1);
  assign mem_rd_en = state_q == READ && !stall;
  assign rd_cnt_d = mem_rd_en ? (rd_last ? '0 : rd_cnt_q + ADDR_BITS'(1)) : rd_cnt_q;
  assign mem_addr = rd_cnt_q;
  assign pix_valid = pix_valid_q;
  // the memory's output register supplies the delay, so its data lines up with pix_valid_q
  assign pix_out = pix_valid_q ? mem_data : '0;
  assign win_valid = pix_valid_q && d_row >= 5'(FILTER_SIZE - 1) && d_col >= 5'(FILTER_SIZE - 1);
  assign win_row = win_valid ? d_row - 5'(FILTER_SIZE - 1) : win_row_q;
  assign win_col = win_valid ? d_col - 5'(FILTER_SIZE - 1) : win_col_q;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? READ : IDLE;
      READ:    state_d = (mem_rd_en && rd_last) ? FLUSH : READ;
      FLUSH:   state_d = (pix_valid_q && d_last) ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      pix_valid_q <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      pix_valid_q <= mem_rd_en;
      win_row_q <= win_row;
      win_col_q <= win_col;
    end
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb_conv1_frame_ctrl: randomized frame tests against a raster/window scoreboard model
module tb_conv1_frame_ctrl;
  localparam int W = 28, H = 28, F = 5, NPIX = W * H, NWIN = (W - F + 1) * (H - F + 1);
  logic clk = 0, rst = 1, start = 0, stall = 0;
  logic mem_rd_en, pix_valid, win_valid, busy, frame_done;
  logic [9:0] mem_addr;
  logic [7:0] mem_data = '0, pix_out;
  logic [4:0] win_row, win_col;
  logic [7:0] mem [1024];
  int n_tests = 0, n_fail = 0, cyc = 0;
  int rd_exp, pix_exp, nwin, ndone, nbusy, first_win, tot_done = 0;
  int wr_m = 0, wc_m = 0, mr, mc;
  bit mon_en = 0, rd_prev = 0, ew;

  conv1_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    rd_exp = 0; pix_exp = 0; nwin = 0; ndone = 0; nbusy = 0; first_win = -1;
  endtask

  task automatic fill(input bit ramp);
    for (int i = 0; i < 1024; i++) mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  // scoreboard: pixel k of a frame is mem[k] at raster (k/W, k%W); it closes a window when both are >= F-1
  always @(negedge clk) begin
    if (rst) begin
      rd_prev = 0; wr_m = 0; wc_m = 0;
    end else if (mon_en) begin
      if (stall) chk("read_during_stall", mem_rd_en, 0);
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr, rd_exp);
        rd_exp++;
      end
      chk("pix_valid_latency", pix_valid, rd_prev);
      ew = 0;
      if (pix_valid) begin
        mr = pix_exp / W;
        mc = pix_exp % W;
        ew = mr >= F - 1 && mc >= F - 1;
        chk("pix_out", pix_out, mem[pix_exp % 1024]);
        if (ew) begin
          wr_m = mr - (F - 1);
          wc_m = mc - (F - 1);
          nwin++;
        end
        if (win_valid && first_win < 0) first_win = pix_exp;
        pix_exp++;
      end
      chk("win_valid", win_valid, ew);
      chk("win_row", win_row, wr_m);
      chk("win_col", win_col, wc_m);
      if (frame_done) begin ndone++; tot_done++; end
      if (busy) nbusy++;
      rd_prev = mem_rd_en;
    end
  end

  // mode: 0 none, 1 ten-cycle stall after addr 50, 2 stall on final read, 3 random stall
  task automatic run_frame(input int mode, input bit mid_start, input bit done_start);
    int c0, stc;
    bit fired;
    clr_model();
    stc = 0;
    fired = 0;
    c0 = cyc;
    start = 1;
    tick();
    start = 0;
    if (mode == 0) begin
      chk("first_rd_en", mem_rd_en, 1);
      chk("first_rd_addr", mem_addr, 0);
      chk("first_busy", busy, 1);
      chk("no_pix_yet", pix_valid, 0);
    end
    for (int k = 0; k < 4000 && pix_exp < NPIX; k++) begin
      if (k == 1 && mode == 0) chk("first_pix_valid", pix_valid, 1);
      start = 0;
      stall = 0;
      if (mode == 1 && rd_exp >= 51 && stc < 10) begin stall = 1; stc++; end
      if (mode == 2 && rd_exp == NPIX - 1 && stc < 5) begin stall = 1; stc++; end
      if (mode == 3) stall = $urandom_range(0, 2) == 0;
      if (mid_start && !fired && rd_exp >= 100) begin start = 1; fired = 1; end
      tick();
      if (mode == 2 && stc > 0 && stc < 5) chk("final_read_held", busy && rd_exp == NPIX - 1, 1);
    end
    chk("npix", pix_exp, NPIX);
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 1);
    if (mode == 0) chk("span", cyc - c0 + 1, 787);
    if (mode == 3) stall = 1;
    start = done_start;
    tick();
    start = 0;
    stall = 0;
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
    chk("ndone", ndone, 1);
    chk("nwin", nwin, NWIN);
    chk("nrd", rd_exp, NPIX);
    chk("first_win", first_win, 116);
    chk("last_win_row", win_row, H - F);
    chk("last_win_col", win_col, W - F);
    if (mode == 0) chk("nbusy", nbusy, 786);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", {pix_valid, pix_out}, 0);
    chk("rst_win", {win_valid, win_row, win_col}, 0);
    chk("rst_busy_done", {busy, frame_done}, 0);
    rst = 0;
    mon_en = 1;
    tick();
    chk("idle_hold", busy, 0);
    fill(1);
    run_frame(0, 0, 0);
    fill(0);
    run_frame(1, 0, 0);
    fill(0);
    run_frame(2, 0, 0);
    fill(0);
    tot_done = 0;
    run_frame(3, 1, 1);
    run_frame(0, 0, 0);
    chk("b2b_total_done", tot_done, 2);
    tick();
    clr_model();
    fill(0);
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 2000 && pix_exp < 300; k++) tick();
    rst = 1;
    #1;
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_pix", {pix_valid, pix_out}, 0);
    chk("arst_win", {win_valid, win_row, win_col}, 0);
    chk("arst_busy_done", {busy, frame_done}, 0);
    tick();
    tick();
    rst = 0;
    repeat (3) tick();
    chk("abort_ndone", ndone, 0);
    chk("abort_busy", busy, 0);
    fill(0);
    run_frame(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv1_frame_ctrl.md
Name: conv1_frame_ctrl

Overview:
Frame sequencer for the first convolution stage. On a start pulse it reads one WIDTH x HEIGHT image from a 1-cycle-latency pixel memory in raster order and streams the pixels into the 5x5 window buffer. It tags each pixel that completes a valid FILTER_SIZE x FILTER_SIZE window with that window's top-left coordinates. It supports downstream stall and reports busy and frame_done to the top-level control.

Parameters:
WIDTH, 28, image width in pixels
HEIGHT, 28, image height in pixels
FILTER_SIZE, 5, convolution window edge
DATA_BITS, 8, pixel width
ADDR_BITS, 10, memory address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to process a frame; honoured only in IDLE
stall  in  1  downstream hold; blocks new memory reads while high
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_BITS  pixel address = row*WIDTH + col
mem_data  in  DATA_BITS  read data, valid 1 cycle after mem_rd_en
pix_out  out  DATA_BITS  pixel to window buffer
pix_valid  out  1  pix_out valid this cycle
win_valid  out  1  with pix_valid: this pixel completes a window
win_row  out  5  top-left row of completed window (0..HEIGHT-FILTER_SIZE)
win_col  out  5  top-left col of completed window (0..WIDTH-FILTER_SIZE)
busy  out  1  high from the cycle after an accepted start until the frame_done cycle inclusive
frame_done  out  1  one-cycle pulse after the last pixel is delivered

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: mem_rd_en, mem_addr, pix_out, pix_valid, win_valid, win_row, win_col, busy, frame_done. Read and delivery counters are cleared to 0.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE: start=1 -> READ and busy<=1. Otherwise hold.
- READ: mem_rd_en = !stall (combinational from the state register and stall). mem_addr = rd_cnt. rd_cnt increments on each issued read.
- READ exit: when the read at rd_cnt = WIDTH*HEIGHT-1 is issued -> FLUSH.
- FLUSH: no reads. The FSM goes to DONE in the cycle after the last pixel is delivered.
- DONE: frame_done=1 for exactly one cycle, busy stays 1, then IDLE with busy<=0.
- Delivery: pix_valid and pix_out are registered copies of mem_rd_en (delayed 1 cycle) and mem_data. Read-to-pix_valid latency is 1 cycle. The first pix_valid appears 2 cycles after start.
- Stall semantics:
  - Stall gates read issue only. A read issued before stall rose still delivers; pixels are never dropped or duplicated.
  - pix_valid drops one cycle after stall rises and resumes one cycle after stall falls.
- Delivery counters: d_col 0..WIDTH-1 and d_row 0..HEIGHT-1 advance on each pix_valid in raster order. d_col wraps to 0 and d_row increments at d_col=WIDTH-1.
- Window tagging: win_valid=1 iff pix_valid and d_row>=FILTER_SIZE-1 and d_col>=FILTER_SIZE-1. Then win_row = d_row-(FILTER_SIZE-1) and win_col = d_col-(FILTER_SIZE-1). When win_valid=0, win_row and win_col hold their last values.
- Counts per frame: exactly WIDTH*HEIGHT=784 pix_valid and (WIDTH-FILTER_SIZE+1)*(HEIGHT-FILTER_SIZE+1)=576 win_valid. The first window is at pixel index 116, which is (row 4, col 4).
- Boundary conditions:
  - start while not IDLE: ignored.
  - start in the DONE cycle: ignored.
  - start in the first IDLE cycle after DONE: accepted (back-to-back frames).
  - stall high in the cycle of the final read: that read is deferred. The FSM stays in READ until the read issues.
  - stall during FLUSH or DONE: no effect.
  - Reset mid-frame: immediate abort to IDLE. The partially delivered frame is abandoned with no frame_done.
- Widths: rd_cnt is ADDR_BITS wide. d_row and d_col are 5 bits. Comparisons are unsigned.

Decomposition:
- Package conv1_pkg holds:
  - constants WIDTH, HEIGHT, FILTER_SIZE;
  - derived NUM_PIX=WIDTH*HEIGHT, OUT_W=WIDTH-FILTER_SIZE+1, OUT_H=HEIGHT-FILTER_SIZE+1, NUM_WIN=OUT_W*OUT_H;
  - the FSM state encoding (2-bit).
- Sub-module conv1_raster_cnt: enable-driven col/row counter with wrap and a last flag, used for the delivery counters. The read side uses a linear counter.

Test Plan:
- Basic frame: mem[i]=i[7:0], start pulse, stall=0 -> 784 pix_valid with pix_out=i[7:0]; 576 win_valid; first win_valid at pixel 116 with win_row=0, win_col=0; last at pixel 783 with win_row=23, win_col=23; frame_done 1 cycle after pixel 783; busy low the cycle after.
- Latency: start at cycle T -> mem_rd_en=1 with addr 0 at T+1, pix_valid at T+2, total busy span 787 cycles.
- Stall: assert stall for 10 cycles after addr 50 is issued -> no reads issued during the stall; pixel 50 is still delivered; delivery resumes at pixel 51 in order; totals remain 784/576.
- Final-read stall: stall high when rd_cnt=783 -> FSM stays READ, addr 783 is issued after stall falls, frame_done follows correctly.
- Control edges:
  - start during READ -> ignored, exactly one frame_done;
  - start in the DONE cycle -> ignored;
  - start in the next IDLE cycle -> second frame runs, 2 frame_done total.
- Reset mid-frame: rst at pixel 300 -> all outputs 0 asynchronously, no frame_done; a new start gives a full correct frame from addr 0.
